// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// Module : present_pkg
// Brief  : Shared widths and skid-buffer state encoding for the PRESENT
//          datapath selector.
// Rev    : 1.0  initial release
// ============================================================================
package present_pkg;

  localparam int PRESENT_KEY_W   = 80;
  localparam int PRESENT_STATE_W = 64;

  // Occupancy of the 2-entry skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Select width for n channels; a 1-channel or 2-channel mux still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_skid_reg.sv
`default_nettype none
// ============================================================================
// Module : present_skid_reg
// Brief  : 2-entry registered skid buffer with valid/ready on both sides.
//          Main entry drives the output; skid entry absorbs one word while
//          the output is stalled. in_ready is registered.
// Rev    : 1.0  initial release
// ============================================================================
module present_skid_reg
  import present_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             ready_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid & ready_q;
  assign out_xfer  = (state_q != EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  // State, storage and the registered ready flag; reset drops every held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
    end
  end

  // Next occupancy and entry loads; data registers change only on a transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // ready_q is low here, so no input can arrive in this state.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/present_mux_nx1_skid.sv
`default_nettype none
// ============================================================================
// Module : present_mux_nx1_skid
// Brief  : N-to-1 channel selector for the PRESENT key/state load paths with
//          a registered 2-entry skid output. Out-of-range selects forward
//          channel 0 with tag 0 and raise a sticky error flag.
// Rev    : 1.0  initial release
// ============================================================================
module present_mux_nx1_skid
  import present_pkg::*;
#(
  parameter int  WIDTH = PRESENT_KEY_W,
  parameter int  N_IN  = 2,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  // Full power-of-two decode table; slots past N_IN alias channel 0.
  localparam int N_SLOT = 1 << SEL_W;

  logic [WIDTH-1:0]       chan [N_SLOT];
  logic                   sel_bad;
  logic [SEL_W-1:0]       sel_tag;
  logic [WIDTH-1:0]       sel_data;
  logic                   err_q;
  logic [SEL_W+WIDTH-1:0] pack_in;
  logic [SEL_W+WIDTH-1:0] pack_out;

  generate
    for (genvar k = 0; k < N_SLOT; k++) begin : g_chan
      if (k < N_IN) begin : g_real
        assign chan[k] = in_data[k*WIDTH +: WIDTH];
      end else begin : g_alias
        assign chan[k] = in_data[WIDTH-1:0];
      end
    end

    if (N_IN == N_SLOT) begin : g_pow2
      assign sel_bad = 1'b0;
    end else begin : g_npow2
      localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_IN - 1);
      assign sel_bad = (in_sel > MAX_SEL);
    end
  endgenerate

  assign sel_data = chan[in_sel];
  assign sel_tag  = sel_bad ? '0 : in_sel;
  assign pack_in  = {sel_tag, sel_data};
  assign out_sel  = pack_out[SEL_W+WIDTH-1:WIDTH];
  assign out_data = pack_out[WIDTH-1:0];
  assign sel_err  = err_q;

  // Sticky flag: set when an out-of-range select is actually accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_valid && in_ready && sel_bad) begin
      err_q <= 1'b1;
    end
  end

  present_skid_reg #(
    .WIDTH (SEL_W + WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (pack_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (pack_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
`default_nettype wire
